// File: rtl/line_fill_memory_if.sv
// line_fill_memory_if
//   Bus between the cache miss logic (master) and the line-fill memory
//   responder (slave).
//   Request channel : reqValid/reqReady handshake, reqWrite, reqAddr (word address)
//   Write channel   : wrValid/wrReady handshake, wrData, wrDone completion pulse
//   Read channel    : rdValid, rdData, rdLast (no backpressure)
//   Status          : err, valid alongside rdValid or wrDone
interface line_fill_memory_if #(
  parameter int DATA_W = 32
);
  logic              reqValid;
  logic              reqReady;
  logic              reqWrite;
  logic [31:0]       reqAddr;
  logic              wrValid;
  logic              wrReady;
  logic [DATA_W-1:0] wrData;
  logic              wrDone;
  logic              rdValid;
  logic [DATA_W-1:0] rdData;
  logic              rdLast;
  logic              err;

  modport master (
    output reqValid, reqWrite, reqAddr, wrValid, wrData,
    input  reqReady, wrReady, wrDone, rdValid, rdData, rdLast, err
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, wrValid, wrData,
    output reqReady, wrReady, wrDone, rdValid, rdData, rdLast, err
  );
endinterface

// File: rtl/line_fill_memory.sv
// line_fill_memory
//   Main-memory responder behind the cache miss interface. Serves line-fill
//   reads and line write-backs as LINE_WORDS-beat bursts after a fixed
//   LATENCY. The backing store powers up holding mem[i] = i*5 and is never
//   cleared by reset, so write-backs survive a reset.
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high
//   bus (slave)    request / write-beat / read-beat channels plus err status
//   led1..led4     debug view of mem[1][3:0] (led1 = bit 0)
// Configuration
//   MEM_LED_DEBUG_EN defined : leds show a registered copy of mem[1][3:0]
//   MEM_LED_DEBUG_EN undefined: leds tied low, no extra read port
module line_fill_memory #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LINE_WORDS  = 4,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              reset,
  line_fill_memory_if.slave bus,
  output logic              led1,
  output logic              led2,
  output logic              led3,
  output logic              led4
);

  localparam int AW      = $clog2(DEPTH_WORDS);
  localparam int LW      = $clog2(LINE_WORDS);
  localparam int LINE_AW = AW - LW;
  localparam logic [LW-1:0] LAST_BEAT = LW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WDATA, WAIT, BURST, ACK} state_t;

  typedef logic [DEPTH_WORDS-1:0][DATA_W-1:0] memArray_t;

  function automatic memArray_t initMem();
    memArray_t m;
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      m[i] = DATA_W'(i * 5);
    end
    return m;
  endfunction

  // Backing store with its power-up pattern; deliberately outside reset
  memArray_t mem = initMem();

  state_t              state_q, state_d;
  logic [LINE_AW-1:0]  lineIdx_q, lineIdx_d;
  logic                write_q, write_d;
  logic                oor_q, oor_d;
  logic [LW-1:0]       beat_q, beat_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rdValid_q, rdValid_d;
  logic [DATA_W-1:0]   rdData_q, rdData_d;
  logic                rdLast_q, rdLast_d;
  logic                wrDone_q, wrDone_d;
  logic                err_q, err_d;

  logic [31:0]         lineBase;
  logic [AW-1:0]       memAddr;
  logic                memWe;

  // Line-aligned request address; beats only ever vary the low index bits,
  // so a burst can never spill into the neighbouring line.
  assign lineBase = bus.reqAddr & ~32'(LINE_WORDS - 1);
  assign memAddr  = {lineIdx_q, beat_q};
  assign memWe    = (state_q == WDATA) && bus.wrValid && !oor_q;

  assign bus.reqReady = (state_q == IDLE) && !reset;
  assign bus.wrReady  = (state_q == WDATA);
  assign bus.rdValid  = rdValid_q;
  assign bus.rdData   = rdData_q;
  assign bus.rdLast   = rdLast_q;
  assign bus.wrDone   = wrDone_q;
  assign bus.err      = err_q;

  // State and registered outputs; reset aborts any transfer at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lineIdx_q <= '0;
      write_q   <= 1'b0;
      oor_q     <= 1'b0;
      beat_q    <= '0;
      cnt_q     <= '0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      rdLast_q  <= 1'b0;
      wrDone_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lineIdx_q <= lineIdx_d;
      write_q   <= write_d;
      oor_q     <= oor_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      rdValid_q <= rdValid_d;
      rdData_q  <= rdData_d;
      rdLast_q  <= rdLast_d;
      wrDone_q  <= wrDone_d;
      err_q     <= err_d;
    end
  end

  // Write beats land in the store the cycle they are accepted
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= bus.wrData;
    end
  end

  // Next state. BURST and ACK each linger one cycle past their last
  // output so the responder only reopens after rdLast/wrDone has been seen.
  always_comb begin
    state_d   = state_q;
    lineIdx_d = lineIdx_q;
    write_d   = write_q;
    oor_d     = oor_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    rdValid_d = 1'b0;
    rdData_d  = '0;
    rdLast_d  = 1'b0;
    wrDone_d  = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          lineIdx_d = lineBase[AW-1:LW];
          write_d   = bus.reqWrite;
          oor_d     = (lineBase >= 32'(DEPTH_WORDS));
          beat_d    = '0;
          cnt_d     = 8'(LATENCY);
          if (bus.reqWrite) begin
            state_d = WDATA;
          end else if (LATENCY > 0) begin
            state_d = WAIT;
          end else begin
            state_d = BURST;
          end
        end
      end

      WDATA: begin
        if (bus.wrValid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = (LATENCY > 0) ? WAIT : ACK;
          end
        end
      end

      WAIT: begin
        if (cnt_q <= 8'd1) begin
          state_d = write_q ? ACK : BURST;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      BURST: begin
        if (rdLast_q) begin
          state_d = IDLE;
        end else begin
          rdValid_d = 1'b1;
          rdData_d  = oor_q ? '0 : mem[memAddr];
          rdLast_d  = (beat_q == LAST_BEAT);
          err_d     = oor_q;
          beat_d    = beat_q + 1'b1;
        end
      end

      ACK: begin
        if (wrDone_q) begin
          state_d = IDLE;
        end else begin
          wrDone_d = 1'b1;
          err_d    = oor_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_LED_DEBUG_EN
  logic [3:0] ledBits_q;

  // Debug copy of mem[1][3:0]; not reset so it keeps tracking the store
  always_ff @(posedge clk) begin
    ledBits_q <= mem[1][3:0];
  end

  assign {led4, led3, led2, led1} = ledBits_q;
`else
  assign {led4, led3, led2, led1} = 4'b0000;
`endif

endmodule

// File: tb/tb_line_fill_memory.sv
// tb_line_fill_memory
//   Directed bench for line_fill_memory with default parameters
//   (DATA_W=32, DEPTH_WORDS=1024, LINE_WORDS=4, LATENCY=4).
module tb_line_fill_memory;

  logic clk;
  logic reset;
  logic led1, led2, led3, led4;

  int checks = 0;
  int passes = 0;

  line_fill_memory_if #(.DATA_W(32)) bus ();

  line_fill_memory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .led1  (led1),
    .led2  (led2),
    .led3  (led3),
    .led4  (led4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) passes = passes + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic write,
                               input logic [31:0] addr);
    bus.reqValid = valid;
    bus.reqWrite = write;
    bus.reqAddr  = addr;
  endtask

  // Line fill: accept, LATENCY quiet cycles, four beats, then idle again
  task automatic readLine(input string tag, input logic [31:0] addr,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3,
                          input logic errExp, input logic holdReq);
    logic [31:0] exp[4];
    exp = '{e0, e1, e2, e3};
    checkOutput({tag, " ready"}, 32'(bus.reqReady), 32'd1);
    applyStimulus(1'b1, 1'b0, addr);
    tick();
    if (!holdReq) applyStimulus(1'b0, 1'b0, 32'd0);
    repeat (4) tick();
    checkOutput({tag, " latency quiet"}, 32'(bus.rdValid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("%s beat%0d valid", tag, k), 32'(bus.rdValid), 32'd1);
      checkOutput($sformatf("%s beat%0d data", tag, k), bus.rdData, exp[k]);
      checkOutput($sformatf("%s beat%0d last", tag, k), 32'(bus.rdLast), (k == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s beat%0d err", tag, k), 32'(bus.err), 32'(errExp));
    end
    checkOutput({tag, " busy on last"}, 32'(bus.reqReady), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    tick();
    checkOutput({tag, " after valid"}, 32'(bus.rdValid), 32'd0);
    checkOutput({tag, " after ready"}, 32'(bus.reqReady), 32'd1);
  endtask

  // Write-back: accept, four beats (optional one-cycle gaps), wrDone pulse
  task automatic writeLine(input string tag, input logic [31:0] addr,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input logic [3:0] gapMask, input logic errExp,
                           input logic holdReq);
    logic [31:0] dat[4];
    dat = '{d0, d1, d2, d3};
    checkOutput({tag, " ready"}, 32'(bus.reqReady), 32'd1);
    applyStimulus(1'b1, 1'b1, addr);
    tick();
    if (!holdReq) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput({tag, " wrReady"}, 32'(bus.wrReady), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (gapMask[k]) begin
        bus.wrValid = 1'b0;
        tick();
        checkOutput($sformatf("%s gap%0d stall", tag, k), 32'(bus.wrReady), 32'd1);
      end
      bus.wrValid = 1'b1;
      bus.wrData  = dat[k];
      tick();
    end
    bus.wrValid = 1'b0;
    bus.wrData  = 32'd0;
    checkOutput({tag, " wrReady drop"}, 32'(bus.wrReady), 32'd0);
    repeat (4) tick();
    checkOutput({tag, " wrDone early"}, 32'(bus.wrDone), 32'd0);
    tick();
    checkOutput({tag, " wrDone"}, 32'(bus.wrDone), 32'd1);
    checkOutput({tag, " err"}, 32'(bus.err), 32'(errExp));
    checkOutput({tag, " busy on done"}, 32'(bus.reqReady), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    tick();
    checkOutput({tag, " wrDone pulse"}, 32'(bus.wrDone), 32'd0);
    checkOutput({tag, " after ready"}, 32'(bus.reqReady), 32'd1);
  endtask

  initial begin
    reset       = 1'b0;
    bus.wrValid = 1'b0;
    bus.wrData  = 32'd0;
    applyStimulus(1'b0, 1'b0, 32'd0);
    #2 reset = 1'b1;
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst reqReady", 32'(bus.reqReady), 32'd0);
    checkOutput("rst wrReady", 32'(bus.wrReady), 32'd0);
    checkOutput("rst rdValid", 32'(bus.rdValid), 32'd0);
    checkOutput("rst rdData", bus.rdData, 32'd0);
    checkOutput("rst rdLast", 32'(bus.rdLast), 32'd0);
    checkOutput("rst wrDone", 32'(bus.wrDone), 32'd0);
    checkOutput("rst err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();
`ifdef MEM_LED_DEBUG_EN
    checkOutput("led initial", 32'({led4, led3, led2, led1}), 32'h5);
`else
    checkOutput("led tied", 32'({led4, led3, led2, led1}), 32'h0);
`endif

    $display("[TB] aligned read");
    readLine("rd8", 32'd8, 32'd40, 32'd45, 32'd50, 32'd55, 1'b0, 1'b0);

    $display("[TB] write-back then read back");
    writeLine("wr4", 32'd4, 32'hA1, 32'hB2, 32'hC3, 32'hD4, 4'b0000, 1'b0, 1'b0);
    readLine("rd4", 32'd4, 32'hA1, 32'hB2, 32'hC3, 32'hD4, 1'b0, 1'b0);

    $display("[TB] unaligned read");
    readLine("rd10", 32'd10, 32'd40, 32'd45, 32'd50, 32'd55, 1'b0, 1'b0);

    $display("[TB] out-of-range accesses");
    readLine("rd1024", 32'd1024, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    writeLine("wr1024", 32'd1024, 32'h11, 32'h22, 32'h33, 32'h44, 4'b0000, 1'b1, 1'b0);
    readLine("rd0", 32'd0, 32'd0, 32'd5, 32'd10, 32'd15, 1'b0, 1'b0);

    $display("[TB] held request and write beat gaps");
    readLine("rd8hold", 32'd8, 32'd40, 32'd45, 32'd50, 32'd55, 1'b0, 1'b1);
    writeLine("wr16gap", 32'd16, 32'h1001, 32'h1002, 32'h1003, 32'h1004, 4'b1010, 1'b0, 1'b1);
    readLine("rd16", 32'd16, 32'h1001, 32'h1002, 32'h1003, 32'h1004, 1'b0, 1'b0);

    $display("[TB] reset during read burst");
    applyStimulus(1'b1, 1'b0, 32'd8);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    repeat (6) tick();
    checkOutput("rstrd beat1 data", bus.rdData, 32'd45);
    reset = 1'b1;
    tick();
    checkOutput("rstrd rdValid", 32'(bus.rdValid), 32'd0);
    checkOutput("rstrd rdLast", 32'(bus.rdLast), 32'd0);
    checkOutput("rstrd ready held", 32'(bus.reqReady), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("rstrd ready", 32'(bus.reqReady), 32'd1);
    checkOutput("rstrd quiet", 32'(bus.rdValid), 32'd0);

    $display("[TB] reset during write beats");
    applyStimulus(1'b1, 1'b1, 32'd12);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    bus.wrValid = 1'b1;
    bus.wrData  = 32'hAAAA0001;
    tick();
    bus.wrData  = 32'hAAAA0002;
    tick();
    bus.wrValid = 1'b0;
    bus.wrData  = 32'd0;
    reset = 1'b1;
    #1;
    checkOutput("rstwr wrReady", 32'(bus.wrReady), 32'd0);
    tick();
    checkOutput("rstwr wrDone", 32'(bus.wrDone), 32'd0);
    reset = 1'b0;
    tick();
    readLine("rd12", 32'd12, 32'hAAAA0001, 32'hAAAA0002, 32'd70, 32'd75, 1'b0, 1'b0);

    $display("[TB] debug leds after write to word 1");
    writeLine("wr0", 32'd0, 32'h0, 32'hF, 32'hA, 32'hF, 4'b0000, 1'b0, 1'b0);
    tick();
`ifdef MEM_LED_DEBUG_EN
    checkOutput("led word1", 32'({led4, led3, led2, led1}), 32'hF);
`else
    checkOutput("led word1", 32'({led4, led3, led2, led1}), 32'h0);
`endif
    readLine("rd0b", 32'd0, 32'h0, 32'hF, 32'hA, 32'hF, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
